mux_sel_serializer: RTL and testbench

MUX_SEL_SERIALIZER -- requirements
Module: mux_sel_serializer

---
 rtl/mux_sel_serializer.sv | 141 ++++++++++++++
 tb/tb_mux_sel_serializer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_serializer.sv
// Serializes an 8-bit word via an external 8:1 mux (sel/mux_in -> mux_y), with optional even parity bit.
// Latency: first bit one edge after load; sout holds under backpressure (advance = !sout_valid || sout_ready).
module mux_sel_serializer (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   input  logic       msb_first,
   input  logic       par_en,
   output logic [2:0] sel,
   output logic [7:0] mux_in,
   input  logic       mux_y,
   output logic       sout,
   output logic       sout_valid,
   input  logic       sout_ready,
   output logic       sof,
   output logic       eof,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] mux_in_q, mux_in_d;
   logic       parity_q, parity_d;
   logic       msb_q, msb_d;
   logic       par_en_q, par_en_d;
   logic       sout_q, sout_d;
   logic       sout_valid_q, sout_valid_d;
   logic       sof_q, sof_d;
   logic       eof_q, eof_d;
   logic       advance;

   assign advance = !sout_valid_q || sout_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         sel_q        <= 3'd0;
         mux_in_q     <= 8'd0;
         parity_q     <= 1'b0;
         msb_q        <= 1'b0;
         par_en_q     <= 1'b0;
         sout_q       <= 1'b0;
         sout_valid_q <= 1'b0;
         sof_q        <= 1'b0;
         eof_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sel_q        <= sel_d;
         mux_in_q     <= mux_in_d;
         parity_q     <= parity_d;
         msb_q        <= msb_d;
         par_en_q     <= par_en_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         sof_q        <= sof_d;
         eof_q        <= eof_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sel_d        = sel_q;
      mux_in_d     = mux_in_q;
      parity_d     = parity_q;
      msb_d        = msb_q;
      par_en_d     = par_en_q;
      sout_d       = sout_q;
      sout_valid_d = sout_valid_q;
      sof_d        = sof_q;
      eof_d        = eof_q;

      case (state_q)
         IDLE: begin
            // The previous frame's last bit may still be pending while a new word loads.
            if (sout_valid_q && sout_ready) begin
               sout_valid_d = 1'b0;
            end
            if (din_valid) begin
               mux_in_d = din;
               msb_d    = msb_first;
               par_en_d = par_en;
               parity_d = ^din;
               cnt_d    = 3'd0;
               sel_d    = msb_first ? 3'd7 : 3'd0;
               state_d  = SHIFT;
            end
         end

         SHIFT: begin
            if (advance) begin
               sout_d       = mux_y;
               sout_valid_d = 1'b1;
               sof_d        = (cnt_q == 3'd0);
               eof_d        = (cnt_q == 3'd7) && !par_en_q;
               cnt_d        = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  state_d = par_en_q ? PARITY : IDLE;
               end else begin
                  sel_d = msb_q ? (sel_q - 3'd1) : (sel_q + 3'd1);
               end
            end
         end

         PARITY: begin
            if (advance) begin
               sout_d       = parity_q;
               sout_valid_d = 1'b1;
               sof_d        = 1'b0;
               eof_d        = 1'b1;
               state_d      = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign din_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign sel        = sel_q;
   assign mux_in     = mux_in_q;
   assign sout       = sout_q;
   assign sout_valid = sout_valid_q;
   assign sof        = sof_q;
   assign eof        = eof_q;

endmodule

// File: tb/tb_mux_sel_serializer.sv
// Bench for mux_sel_serializer: models the external 8:1 mux, scoreboards every serial bit.
module tb_mux_sel_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       msb_first;
   logic       par_en;
   logic [2:0] sel;
   logic [7:0] mux_in;
   logic       mux_y;
   logic       sout;
   logic       sout_valid;
   logic       sout_ready;
   logic       sof;
   logic       eof;
   logic       busy;

   always #5 clk = ~clk;

   assign mux_y = mux_in[sel];

   mux_sel_serializer dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .msb_first  (msb_first),
      .par_en     (par_en),
      .sel        (sel),
      .mux_in     (mux_in),
      .mux_y      (mux_y),
      .sout       (sout),
      .sout_valid (sout_valid),
      .sout_ready (sout_ready),
      .sof        (sof),
      .eof        (eof),
      .busy       (busy)
   );

   typedef struct {
      logic b;
      logic s;
      logic e;
   } exp_t;

   exp_t       exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         pops  = 0;
   int         ready_ctl = 0;
   logic [7:0] cur_word = 8'd0;
   logic       cur_msb = 1'b0;
   int         cur_n = 8;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a frame is the word's bits in the chosen order, then optionally its even parity.
   task automatic push_frame(input logic [7:0] w, input logic m, input logic p);
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         e.b = m ? w[7 - i] : w[i];
         e.s = (i == 0);
         e.e = (i == 7) && !p;
         exp_q.push_back(e);
      end
      if (p) begin
         e.b = ^w;
         e.s = 1'b0;
         e.e = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   // Monitor: inputs change just after posedge, so negedge values are what the next edge sees.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            cur_n = 8;
            chk("rst_sout_valid", 32'(sout_valid), 32'd0);
            chk("rst_sout", 32'(sout), 32'd0);
            chk("rst_sof_eof", 32'({sof, eof}), 32'd0);
            chk("rst_busy_ready", 32'({busy, din_ready}), 32'd1);
            chk("rst_sel", 32'(sel), 32'd0);
            chk("rst_mux_in", 32'(mux_in), 32'd0);
         end else begin
            if (sout_valid && sout_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_bit: got sout=%0b with no bit expected at %0t", sout, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("sout", 32'(sout), 32'(e.b));
                  chk("sof", 32'(sof), 32'(e.s));
                  chk("eof", 32'(eof), 32'(e.e));
                  pops++;
               end
            end
            if (busy) begin
               chk("din_ready_busy", 32'(din_ready), 32'd0);
               chk("mux_in_stable", 32'(mux_in), 32'(cur_word));
               if (cur_n < 8 && (!sout_valid || sout_ready)) begin
                  chk("sel", 32'(sel), 32'(cur_msb ? 7 - cur_n : cur_n));
                  cur_n++;
               end
            end else if (din_valid && din_ready) begin
               push_frame(din, msb_first, par_en);
               cur_word = din;
               cur_msb  = msb_first;
               cur_n    = 0;
            end
         end
      end
   end

   initial begin
      sout_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_ctl)
            0:       sout_ready = 1'b1;
            1:       sout_ready = ($urandom_range(0, 3) != 0);
            default: sout_ready = 1'b0;
         endcase
      end
   end

   task automatic send(input logic [7:0] w, input logic m, input logic p);
      int   t;
      logic ok;
      t  = 0;
      ok = 1'b0;
      din = w;
      msb_first = m;
      par_en = p;
      din_valid = 1'b1;
      while (!ok && t < 300) begin
         @(negedge clk);
         ok = din_ready;
         @(posedge clk);
         #1;
         t++;
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: din_ready got 0 for %0d cycles expected 1", t);
      end
      din_valid = 1'b0;
      din = 8'($urandom);
      msb_first = 1'($urandom);
      par_en = 1'($urandom);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < 600) begin
         @(posedge clk);
         t++;
      end
      #1;
      if (t >= 600) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d bits left expected 0", exp_q.size());
      end
   endtask

   task automatic wait_pops(input int target);
      int t;
      t = 0;
      while (pops < target && t < 200) begin
         @(posedge clk);
         t++;
      end
      #1;
      if (pops < target) begin
         n_cmp++;
         n_bad++;
         $display("FAIL pops_timeout: got %0d bits expected %0d", pops, target);
      end
   endtask

   initial begin
      int base;
      rst = 1'b1;
      din = 8'd0;
      din_valid = 1'b0;
      msb_first = 1'b0;
      par_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      send(8'hA5, 1'b1, 1'b0);
      drain();
      send(8'h01, 1'b0, 1'b1);
      drain();

      base = pops;
      send(8'h3C, 1'b1, 1'b0);
      wait_pops(base + 2);
      ready_ctl = 2;
      repeat (3) @(posedge clk);
      ready_ctl = 0;
      drain();

      base = pops;
      send(8'hF0, 1'b1, 1'b0);
      wait_pops(base + 4);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(sout_valid), 32'd0);
      chk("async_rst_ready", 32'(din_ready), 32'd1);
      chk("async_rst_sel", 32'(sel), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(8'h81, 1'b1, 1'b0);
      drain();

      send(8'hFF, 1'b1, 1'b0);
      send(8'h00, 1'b1, 1'b0);
      drain();

      send(8'hC3, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      din = 8'h55;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      drain();

      ready_ctl = 1;
      for (int i = 0; i < 40; i++) begin
         send(8'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            din = 8'($urandom);
            din_valid = 1'b1;
            @(posedge clk);
            #1;
            din_valid = 1'b0;
         end
      end
      ready_ctl = 0;
      drain();
      repeat (2) @(posedge clk);
      #1;
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
